// File: rtl/mul_div_seq_if.sv
// Operand/result bundle between the instruction decoder and the MUL/DIV sequencer.
interface mul_div_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rh;
    logic [WIDTH-1:0] rl;
    logic [7:0]       flags_out;

    // Decoder side: issues requests and collects results.
    modport master (
        output start, op, a, b,
        input  busy, done, rh, rl, flags_out
    );

    // Sequencer side.
    modport slave (
        input  start, op, a, b,
        output busy, done, rh, rl, flags_out
    );
endinterface

// File: rtl/mul_div_seq.sv
// Iterative unsigned multiplier / restoring divider, one step per clock.
// hi_q/lo_q are shared working registers: MUL uses them as {acc_hi, acc_lo},
// DIV uses them as {remainder, dividend-shifting-into-quotient}.
module mul_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             op_q;
    logic [WIDTH-1:0] opd_q;      // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] rh_q;
    logic [WIDTH-1:0] rl_q;
    logic [7:0]       flags_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [7:0]       flags_d;

    // One datapath step plus the flags the step result would produce if it is the last one.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, opd_q};
        flags_d = '0;
        if (op_q) begin
            // Restoring division: keep the trial difference only if it did not borrow.
            hi_d       = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            lo_d       = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
            flags_d[2] = (lo_d == '0);
        end else begin
            // Shift-add: carry of the add becomes the new MSB after the right shift.
            hi_d       = mul_sum[WIDTH:1];
            lo_d       = {mul_sum[0], lo_q[WIDTH-1:1]};
            flags_d[0] = (hi_d != '0);
            flags_d[5] = (hi_d != '0);
            flags_d[2] = ({hi_d, lo_d} == '0);
        end
    end

    // Control FSM with registered outputs; results only change on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rh_q    <= '0;
            rl_q    <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        cnt_q <= CW'(WIDTH);
                        hi_q  <= '0;
                        if (bus.op) begin
                            opd_q <= bus.b;
                            lo_q  <= bus.a;
                        end else begin
                            opd_q <= bus.a;
                            lo_q  <= bus.b;
                        end
                        if (bus.op && (bus.b == '0)) begin
                            // Divide by zero finishes immediately with the overflow flag.
                            state_q <= DONE;
                            cnt_q   <= '0;
                            rl_q    <= '1;
                            rh_q    <= bus.a;
                            flags_q <= 8'h20;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rh_q    <= hi_d;
                        rl_q    <= lo_d;
                        flags_q <= flags_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rh        = rh_q;
    assign bus.rl        = rl_q;
    assign bus.flags_out = flags_q;
endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: expected results queued at issue, compared on done.
module tb_mul_div_seq;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] rh;
        logic [7:0] rl;
        logic [7:0] flags;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_div_seq_if #(.WIDTH(W)) bus ();

    mul_div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input bit op, input logic [7:0] a, input logic [7:0] b);
        res_t r;
        logic [15:0] p;
        r.flags = 8'h00;
        if (!op) begin
            p    = 16'(a) * 16'(b);
            r.rh = p[15:8];
            r.rl = p[7:0];
            if (r.rh != 8'h00) r.flags = r.flags | 8'h21;
            if (p == 16'h0000) r.flags = r.flags | 8'h04;
        end else if (b == 8'h00) begin
            r.rh    = a;
            r.rl    = 8'hFF;
            r.flags = 8'h20;
        end else begin
            r.rl = a / b;
            r.rh = a % b;
            if (r.rl == 8'h00) r.flags = 8'h04;
        end
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                $display("done: rh=%02h rl=%02h flags=%02h (expect %02h %02h %02h)",
                         bus.rh, bus.rl, bus.flags_out, e.rh, e.rl, e.flags);
                check_val("rh", 32'(bus.rh), 32'(e.rh));
                check_val("rl", 32'(bus.rl), 32'(e.rl));
                check_val("flags", 32'(bus.flags_out), 32'(e.flags));
            end
        end
    end

    // Called at a negedge: start is sampled at the next posedge (edge k); returns in cycle k+1.
    task automatic issue(input bit op, input logic [7:0] a, input logic [7:0] b, input bit push);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
    endtask

    // Measures cycles from accept to done; optionally pulses a stray start sampled at edge k+glitch_at.
    task automatic wait_done(input int exp_lat, input int glitch_at);
        int lat;
        int busy_cnt;
        lat      = 1;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (glitch_at > 0 && lat == glitch_at) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.a     = 8'($urandom);
                bus.b     = 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
    endtask

    initial begin
        int idle_activity;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_busy", 32'(bus.busy), 32'd0);
        check_val("reset_done", 32'(bus.done), 32'd0);
        check_val("reset_rh", 32'(bus.rh), 32'd0);
        check_val("reset_rl", 32'(bus.rl), 32'd0);
        check_val("reset_flags", 32'(bus.flags_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic multiply, carry/overflow and zero cases.
        issue(1'b0, 8'h0C, 8'h0B, 1'b1); wait_done(9, 0);
        issue(1'b0, 8'hFF, 8'hFF, 1'b1); wait_done(9, 0);
        issue(1'b0, 8'h00, 8'h37, 1'b1); wait_done(9, 0);
        // Division, zero quotient, divide by zero.
        issue(1'b1, 8'hC8, 8'h07, 1'b1); wait_done(9, 0);
        issue(1'b1, 8'h03, 8'h09, 1'b1); wait_done(9, 0);
        issue(1'b1, 8'h55, 8'h00, 1'b1); wait_done(1, 0);

        // Stray start during RUN must be ignored.
        issue(1'b0, 8'h12, 8'h34, 1'b1); wait_done(9, 3);

        // Reset mid-operation: outputs cleared, no done, stays idle.
        issue(1'b0, 8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_done", 32'(bus.done), 32'd0);
        check_val("abort_rh", 32'(bus.rh), 32'd0);
        check_val("abort_rl", 32'(bus.rl), 32'd0);
        check_val("abort_flags", 32'(bus.flags_out), 32'd0);
        idle_activity = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) idle_activity++;
        end
        check_val("abort_idle", 32'(idle_activity), 32'd0);

        // Back-to-back: next start issued in the DONE cycle.
        issue(1'b1, 8'hC8, 8'h07, 1'b1); wait_done(9, 0);
        issue(1'b0, 8'h10, 8'h10, 1'b1); wait_done(9, 0);

        // A few random operations, including occasional zero divisors.
        for (int i = 0; i < 8; i++) begin
            bit         op;
            logic [7:0] a;
            logic [7:0] b;
            op = 1'($urandom);
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            issue(op, a, b, 1'b1);
            wait_done((op && b == 8'h00) ? 1 : 9, 0);
        end

        repeat (3) @(negedge clk);
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
